// File: rtl/csr_task_pkg.sv
// Shared CSR offsets and TR/EV bit positions for the per-task timer CSR bank.
package csr_task_pkg;

  typedef enum logic [2:0] {
    OffTev,
    OffWdev,
    OffD1ev,
    OffD2ev,
    OffTr,
    OffEv,
    OffCntSleep,
    OffCntRun
  } csr_off_e;

  localparam int unsigned EvWidth = 4;

  localparam int unsigned TrEn         = 0;
  localparam int unsigned TrAutoReload = 1;
  localparam int unsigned TrWdEn       = 2;
  localparam int unsigned TrMaskLsb    = 8;

  localparam int unsigned EvTimer     = 0;
  localparam int unsigned EvWatchdog  = 1;
  localparam int unsigned EvDeadline1 = 2;
  localparam int unsigned EvDeadline2 = 3;

endpackage

// File: rtl/csr_task_timer_ch.sv
// One task's timer CSRs: presets, control, W1C events, run/sleep counters, timer and deadlines.
// Watchdog storage and logic exist only when CSR_TASK_WATCHDOG_EN is defined.
module csr_task_timer_ch
  import csr_task_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            we_i,
  input  csr_off_e        off_i,
  input  logic [XLEN-1:0] wdata_i,
  input  logic            active_i,
  input  logic            kick_i,
  output logic [XLEN-1:0] rdata_o,
  output logic            irq_o
);

  logic               en_q, en_d, ar_q, ar_d, irq_q, irq_d, en_rise;
  logic [EvWidth-1:0] mask_q, mask_d, ev_q, ev_d, ev_set, ev_clr;
  logic [XLEN-1:0]    tev_q, tev_d, d1_q, d1_d, d2_q, d2_d;
  logic [XLEN-1:0]    run_q, run_d, sleep_q, sleep_d, tcnt_q, tcnt_d;
`ifdef CSR_TASK_WATCHDOG_EN
  logic               wd_en_q, wd_en_d;
  logic [XLEN-1:0]    wdev_q, wdev_d, wcnt_q, wcnt_d;
`else
  logic               unused_kick;
  assign unused_kick = kick_i;
`endif

  always_comb begin
    en_d    = en_q;
    ar_d    = ar_q;
    mask_d  = mask_q;
    tev_d   = tev_q;
    d1_d    = d1_q;
    d2_d    = d2_q;
    run_d   = run_q;
    sleep_d = sleep_q;
    tcnt_d  = tcnt_q;
    ev_set  = '0;
    ev_clr  = '0;
`ifdef CSR_TASK_WATCHDOG_EN
    wd_en_d = wd_en_q;
    wdev_d  = wdev_q;
    wcnt_d  = wcnt_q;
`endif
    en_rise = we_i && (off_i == OffTr) && wdata_i[TrEn] && !en_q;

    if (en_rise) begin
      tcnt_d  = tev_q;
      run_d   = '0;
      sleep_d = '0;
`ifdef CSR_TASK_WATCHDOG_EN
      wcnt_d  = wdev_q;
`endif
    end else if (en_q) begin
      if (active_i) begin
        if (run_q != '1) begin
          run_d = run_q + 1'b1;
          ev_set[EvDeadline1] = (d1_q != '0) && (run_d == d1_q);
          ev_set[EvDeadline2] = (d2_q != '0) && (run_d == d2_q);
        end
      end else if (sleep_q != '1) begin
        sleep_d = sleep_q + 1'b1;
      end
      if (tcnt_q != '0) begin
        tcnt_d = tcnt_q - 1'b1;
        if (tcnt_q == XLEN'(1)) begin
          ev_set[EvTimer] = 1'b1;
          tcnt_d = ar_q ? tev_q : '0;
        end
      end
`ifdef CSR_TASK_WATCHDOG_EN
      if (kick_i) begin
        wcnt_d = wdev_q;
      end else if (wd_en_q && active_i && (wcnt_q != '0)) begin
        wcnt_d = wcnt_q - 1'b1;
        ev_set[EvWatchdog] = (wcnt_q == XLEN'(1));
      end
`endif
    end

    if (we_i) begin
      unique case (off_i)
        OffTev:  tev_d = wdata_i;
        OffWdev: begin
`ifdef CSR_TASK_WATCHDOG_EN
          wdev_d = wdata_i;
`endif
        end
        OffD1ev: d1_d = wdata_i;
        OffD2ev: d2_d = wdata_i;
        OffTr: begin
          en_d   = wdata_i[TrEn];
          ar_d   = wdata_i[TrAutoReload];
          mask_d = wdata_i[TrMaskLsb +: EvWidth];
`ifdef CSR_TASK_WATCHDOG_EN
          wd_en_d = wdata_i[TrWdEn];
`endif
        end
        OffEv:       ev_clr = wdata_i[EvWidth-1:0];
        OffCntSleep: ;
        OffCntRun:   ;
      endcase
    end

    // A hardware set on the same edge as a W1C clear keeps the bit.
    ev_d  = (ev_q & ~ev_clr) | ev_set;
    irq_d = |(ev_q & mask_q);
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      en_q    <= 1'b0;
      ar_q    <= 1'b0;
      mask_q  <= '0;
      ev_q    <= '0;
      irq_q   <= 1'b0;
      tev_q   <= '0;
      d1_q    <= '0;
      d2_q    <= '0;
      run_q   <= '0;
      sleep_q <= '0;
      tcnt_q  <= '0;
`ifdef CSR_TASK_WATCHDOG_EN
      wd_en_q <= 1'b0;
      wdev_q  <= '0;
      wcnt_q  <= '0;
`endif
    end else begin
      en_q    <= en_d;
      ar_q    <= ar_d;
      mask_q  <= mask_d;
      ev_q    <= ev_d;
      irq_q   <= irq_d;
      tev_q   <= tev_d;
      d1_q    <= d1_d;
      d2_q    <= d2_d;
      run_q   <= run_d;
      sleep_q <= sleep_d;
      tcnt_q  <= tcnt_d;
`ifdef CSR_TASK_WATCHDOG_EN
      wd_en_q <= wd_en_d;
      wdev_q  <= wdev_d;
      wcnt_q  <= wcnt_d;
`endif
    end
  end

  always_comb begin
    rdata_o = '0;
    unique case (off_i)
      OffTev:  rdata_o = tev_q;
      OffWdev: begin
`ifdef CSR_TASK_WATCHDOG_EN
        rdata_o = wdev_q;
`endif
      end
      OffD1ev: rdata_o = d1_q;
      OffD2ev: rdata_o = d2_q;
      OffTr: begin
        rdata_o[TrEn]                  = en_q;
        rdata_o[TrAutoReload]          = ar_q;
        rdata_o[TrMaskLsb +: EvWidth]  = mask_q;
`ifdef CSR_TASK_WATCHDOG_EN
        rdata_o[TrWdEn]                = wd_en_q;
`endif
      end
      OffEv:       rdata_o[EvWidth-1:0] = ev_q;
      OffCntSleep: rdata_o = sleep_q;
      OffCntRun:   rdata_o = run_q;
    endcase
  end

  assign irq_o = irq_q;

endmodule

// File: rtl/csr_task_timer_bank.sv
// Per-task timer CSR bank: address decode, read mux and one channel per task.
// Define CSR_TASK_WATCHDOG_EN to build the per-task watchdog.
module csr_task_timer_bank
  import csr_task_pkg::*;
#(
  parameter int unsigned NUM_TASKS   = 4,
  parameter int unsigned XLEN        = 32,
  parameter logic [11:0] BASE_ADDR   = 12'h7E0,
  parameter int unsigned TASK_STRIDE = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [11:0]          csr_addr,
  input  logic [XLEN-1:0]      wdata,
  input  logic                 we,
  output logic [XLEN-1:0]      rdata,
  output logic                 csr_hit,
  input  logic [NUM_TASKS-1:0] task_active,
  input  logic [NUM_TASKS-1:0] wd_kick,
  output logic [NUM_TASKS-1:0] evt_irq
);

  localparam int unsigned Shift   = $clog2(TASK_STRIDE);
  // Offset bits between the 8 implemented CSRs and the stride must be zero.
  localparam logic [11:0] PadMask = 12'((TASK_STRIDE - 1) & ~32'd7);

  logic [11:0]     addr_off, task_idx;
  csr_off_e        off;
  logic [XLEN-1:0] ch_rdata [NUM_TASKS];

  assign addr_off = csr_addr - BASE_ADDR;
  assign task_idx = addr_off >> Shift;
  assign off      = csr_off_e'(addr_off[2:0]);
  assign csr_hit  = (csr_addr >= BASE_ADDR) && ((addr_off & PadMask) == 12'd0) &&
                    (32'(task_idx) < NUM_TASKS);

  for (genvar t = 0; t < NUM_TASKS; t++) begin : g_task
    logic sel;
    assign sel = csr_hit && (task_idx == 12'(t));

    csr_task_timer_ch #(
      .XLEN(XLEN)
    ) u_ch (
      .clk_i   (clk),
      .rst_ni  (reset),
      .we_i    (we && sel),
      .off_i   (off),
      .wdata_i (wdata),
      .active_i(task_active[t]),
      .kick_i  (wd_kick[t]),
      .rdata_o (ch_rdata[t]),
      .irq_o   (evt_irq[t])
    );
  end

  always_comb begin
    rdata = '0;
    for (int unsigned t = 0; t < NUM_TASKS; t++) begin
      if (csr_hit && (task_idx == 12'(t))) rdata = ch_rdata[t];
    end
  end

endmodule

// File: tb/tb_csr_task_timer_bank.sv
// Self-checking bench for csr_task_timer_bank: vector table, corner sequences, random vs model.
module tb_csr_task_timer_bank;

  localparam int unsigned NT     = 4;
  localparam int unsigned XL     = 32;
  localparam logic [11:0] BASE   = 12'h7E0;
  localparam int unsigned STRIDE = 16;
`ifdef CSR_TASK_WATCHDOG_EN
  localparam bit WdOn = 1'b1;
`else
  localparam bit WdOn = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic [11:0]   csr_addr = '0;
  logic [XL-1:0] wdata = '0;
  logic          we = 1'b0;
  logic [XL-1:0] rdata;
  logic          csr_hit;
  logic [NT-1:0] task_active = '0;
  logic [NT-1:0] wd_kick = '0;
  logic [NT-1:0] evt_irq;

  int n_cmp = 0;
  int n_fail = 0;

  csr_task_timer_bank #(
    .NUM_TASKS  (NT),
    .XLEN       (XL),
    .BASE_ADDR  (BASE),
    .TASK_STRIDE(STRIDE)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .csr_addr   (csr_addr),
    .wdata      (wdata),
    .we         (we),
    .rdata      (rdata),
    .csr_hit    (csr_hit),
    .task_active(task_active),
    .wd_kick    (wd_kick),
    .evt_irq    (evt_irq)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish, got running expected done");
    $fatal(1, "timeout");
  end

  typedef struct {
    bit          do_wr;
    logic [11:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rd;
    bit          exp_hit;
  } vec_t;

  vec_t vecs[12];

  // Reference model state (spec-level: elapsed edges, counts, event sets).
  int unsigned m_k[NT], m_run[NT], m_sleep[NT], m_tev[NT], m_d1[NT], m_d2[NT];
  bit          m_en[NT], m_ar[NT];
  bit [3:0]    m_mask[NT], m_ev[NT];
  bit [NT-1:0] m_irq;

  function automatic logic [11:0] ca(input int t, input int off);
    return 12'(int'(BASE) + t * int'(STRIDE) + off);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic rd_chk(input string name, input int t, input int off, input logic [31:0] exp);
    csr_addr = ca(t, off);
    #1;
    chk(name, rdata, exp);
  endtask

  task automatic wr(input int t, input int off, input logic [31:0] d);
    csr_addr = ca(t, off);
    wdata    = d;
    we       = 1'b1;
    tick();
    we       = 1'b0;
  endtask

  task automatic model_clear();
    for (int t = 0; t < NT; t++) begin
      m_k[t] = 0; m_run[t] = 0; m_sleep[t] = 0; m_tev[t] = 0; m_d1[t] = 0; m_d2[t] = 0;
      m_en[t] = 0; m_ar[t] = 0; m_mask[t] = 0; m_ev[t] = 0;
    end
    m_irq = '0;
  endtask

  task automatic model_edge(input bit [NT-1:0] act, input bit w, input int wt, input int woff,
                            input logic [31:0] d);
    bit [3:0] fired, clr;
    for (int t = 0; t < NT; t++) begin
      m_irq[t] = |(m_ev[t] & m_mask[t]);
      fired = '0;
      if (m_en[t]) begin
        m_k[t]++;
        if (act[t]) begin
          m_run[t]++;
          if (m_d1[t] != 0 && m_run[t] == m_d1[t]) fired[2] = 1'b1;
          if (m_d2[t] != 0 && m_run[t] == m_d2[t]) fired[3] = 1'b1;
        end else begin
          m_sleep[t]++;
        end
        if (m_tev[t] != 0 && (m_ar[t] ? (m_k[t] % m_tev[t] == 0) : (m_k[t] == m_tev[t])))
          fired[0] = 1'b1;
      end
      clr = (w && wt == t && woff == 5) ? d[3:0] : 4'h0;
      m_ev[t] = (m_ev[t] & ~clr) | fired;
      if (w && wt == t) begin
        case (woff)
          0: m_tev[t] = d;
          2: m_d1[t] = d;
          3: m_d2[t] = d;
          4: begin
            if (d[0] && !m_en[t]) begin
              m_k[t] = 0; m_run[t] = 0; m_sleep[t] = 0;
            end
            m_en[t] = d[0]; m_ar[t] = d[1]; m_mask[t] = d[11:8];
          end
          default: ;
        endcase
      end
    end
  endtask

  task automatic bus_cycle(input int cyc, input bit w, input int wt, input int woff,
                           input logic [31:0] d, input bit [NT-1:0] act);
    int ct;
    task_active = act;
    if (w) begin
      csr_addr = ca(wt, woff);
      wdata    = d;
      we       = 1'b1;
    end
    model_edge(act, w, wt, woff, d);
    tick();
    we = 1'b0;
    chk($sformatf("rnd irq c%0d", cyc), 32'(evt_irq), 32'(m_irq));
    for (int t = 0; t < NT; t++) rd_chk($sformatf("rnd ev%0d c%0d", t, cyc), t, 5, 32'(m_ev[t]));
    ct = cyc % NT;
    rd_chk($sformatf("rnd run%0d c%0d", ct, cyc), ct, 7, m_run[ct]);
    rd_chk($sformatf("rnd sleep%0d c%0d", ct, cyc), ct, 6, m_sleep[ct]);
  endtask

  initial begin
    bit [NT-1:0] act;
    int          r;

    // Reset and reset-state reads
    repeat (3) tick();
    reset = 1'b1;
    for (int t = 0; t < NT; t++)
      for (int o = 0; o < 8; o++) rd_chk($sformatf("reset t%0d o%0d", t, o), t, o, 32'h0);
    chk("reset irq", 32'(evt_irq), 32'h0);

    // Decode misses and hits
    csr_addr = BASE + 12'd8; #1;
    chk("pad hit", 32'(csr_hit), 32'h0); chk("pad rdata", rdata, 32'h0);
    csr_addr = ca(NT, 0); #1;
    chk("beyond hit", 32'(csr_hit), 32'h0); chk("beyond rdata", rdata, 32'h0);
    csr_addr = BASE - 12'd1; #1;
    chk("below hit", 32'(csr_hit), 32'h0);
    csr_addr = ca(NT - 1, 7); #1;
    chk("last hit", 32'(csr_hit), 32'h1);
    csr_addr = ca(0, 1); #1;
    chk("wdev hit", 32'(csr_hit), 32'h1);

    // Register access table
    vecs[0]  = '{1'b1, ca(1, 0), 32'h12345678, 32'h12345678, 1'b1};
    vecs[1]  = '{1'b1, ca(1, 2), 32'hCAFEF00D, 32'hCAFEF00D, 1'b1};
    vecs[2]  = '{1'b1, ca(1, 3), 32'h00000007, 32'h00000007, 1'b1};
    vecs[3]  = '{1'b1, ca(1, 1), 32'hA5A5A5A5, WdOn ? 32'hA5A5A5A5 : 32'h0, 1'b1};
    vecs[4]  = '{1'b1, ca(1, 4), 32'hFFFFFFFE, WdOn ? 32'h00000F06 : 32'h00000F02, 1'b1};
    vecs[5]  = '{1'b1, ca(1, 5), 32'hFFFFFFFF, 32'h0, 1'b1};
    vecs[6]  = '{1'b1, ca(1, 6), 32'hFFFFFFFF, 32'h0, 1'b1};
    vecs[7]  = '{1'b1, ca(1, 7), 32'hFFFFFFFF, 32'h0, 1'b1};
    vecs[8]  = '{1'b0, ca(0, 0), 32'h0, 32'h0, 1'b1};
    vecs[9]  = '{1'b1, ca(1, 8), 32'h00000001, 32'h0, 1'b0};
    vecs[10] = '{1'b0, ca(1, 0), 32'h0, 32'h12345678, 1'b1};
    vecs[11] = '{1'b1, ca(1, 4), 32'h0, 32'h0, 1'b1};
    for (int i = 0; i < 12; i++) begin
      if (vecs[i].do_wr) begin
        csr_addr = vecs[i].addr; wdata = vecs[i].wdata; we = 1'b1;
        tick();
        we = 1'b0;
      end
      csr_addr = vecs[i].addr; #1;
      chk($sformatf("vec%0d rdata", i), rdata, vecs[i].exp_rd);
      chk($sformatf("vec%0d hit", i), 32'(csr_hit), 32'(vecs[i].exp_hit));
    end

    // One-shot timer with interrupt and W1C
    wr(0, 0, 32'd5);
    wr(0, 4, 32'h101);
    for (int i = 1; i <= 5; i++) begin
      tick();
      rd_chk($sformatf("oneshot ev e%0d", i), 0, 5, (i == 5) ? 32'h1 : 32'h0);
      chk($sformatf("oneshot irq e%0d", i), 32'(evt_irq[0]), 32'h0);
    end
    tick();
    chk("oneshot irq set", 32'(evt_irq[0]), 32'h1);
    wr(0, 5, 32'h1);
    rd_chk("oneshot w1c", 0, 5, 32'h0);
    chk("oneshot irq lag", 32'(evt_irq[0]), 32'h1);
    tick();
    chk("oneshot irq drop", 32'(evt_irq[0]), 32'h0);
    repeat (6) tick();
    rd_chk("oneshot no refire", 0, 5, 32'h0);
    wr(0, 4, 32'h0);

    // Auto-reload period 3, W1C on a firing edge
    wr(1, 0, 32'd3);
    wr(1, 4, 32'h3);
    for (int i = 1; i <= 3; i++) begin
      tick();
      rd_chk($sformatf("auto ev e%0d", i), 1, 5, (i == 3) ? 32'h1 : 32'h0);
    end
    wr(1, 5, 32'h1);
    rd_chk("auto clr e4", 1, 5, 32'h0);
    tick(); rd_chk("auto e5", 1, 5, 32'h0);
    tick(); rd_chk("auto e6", 1, 5, 32'h1);
    tick(); tick();
    wr(1, 5, 32'h1);
    rd_chk("auto w1c race e9", 1, 5, 32'h1);
    wr(1, 5, 32'h1);
    rd_chk("auto clr e10", 1, 5, 32'h0);
    tick(); tick();
    rd_chk("auto e12", 1, 5, 32'h1);
    wr(1, 4, 32'h0);

    // Run/sleep counters and deadline 1
    wr(2, 2, 32'd3);
    wr(2, 4, 32'h1);
    task_active = 4'b0100;
    for (int i = 1; i <= 4; i++) begin
      tick();
      rd_chk($sformatf("dl1 ev a%0d", i), 2, 5, (i >= 3) ? 32'h4 : 32'h0);
    end
    task_active = '0;
    repeat (6) tick();
    rd_chk("cnt run", 2, 7, 32'd4);
    rd_chk("cnt sleep", 2, 6, 32'd6);
    wr(2, 4, 32'h0);
    task_active = 4'b0100;
    repeat (3) tick();
    rd_chk("cnt run hold", 2, 7, 32'd4);
    task_active = '0;

    // Watchdog with periodic kicks, then starved
    wr(3, 1, 32'd4);
    rd_chk("wdev rd", 3, 1, WdOn ? 32'd4 : 32'd0);
    task_active = 4'b1000;
    wr(3, 4, 32'h5);
    rd_chk("wd tr rd", 3, 4, WdOn ? 32'h5 : 32'h1);
    for (int k = 0; k < 4; k++) begin
      tick(); tick();
      wd_kick[3] = 1'b1;
      tick();
      wd_kick[3] = 1'b0;
      rd_chk($sformatf("wd kicked r%0d", k), 3, 5, 32'h0);
    end
    for (int i = 1; i <= 4; i++) begin
      tick();
      rd_chk($sformatf("wd starve e%0d", i), 3, 5, (WdOn && i == 4) ? 32'h2 : 32'h0);
    end
    task_active = '0;
    wr(3, 4, 32'h0);

    // Reset mid-count
    wr(0, 0, 32'd10);
    wr(0, 4, 32'h101);
    repeat (6) tick();
    reset = 1'b0;
    tick();
    reset = 1'b1;
    rd_chk("rst tr", 0, 4, 32'h0);
    rd_chk("rst tev", 0, 0, 32'h0);
    rd_chk("rst ev2", 2, 5, 32'h0);
    rd_chk("rst run2", 2, 7, 32'h0);
    repeat (12) tick();
    rd_chk("rst no event", 0, 5, 32'h0);
    chk("rst irq", 32'(evt_irq), 32'h0);

    // Randomised run against the model
    model_clear();
    for (int t = 0; t < NT; t++) begin
      bus_cycle(0, 1'b1, t, 0, 32'($urandom_range(1, 6)), '0);
      bus_cycle(1, 1'b1, t, 2, 32'($urandom_range(1, 12)), '0);
      bus_cycle(2, 1'b1, t, 3, $urandom_range(0, 1) ? 32'($urandom_range(1, 12)) : 32'h0, '0);
    end
    for (int t = 0; t < NT; t++)
      bus_cycle(t, 1'b1, t, 4, (32'($urandom_range(0, 15)) << 8) |
                (32'($urandom_range(0, 1)) << 1) | 32'h1, '0);
    for (int c = 0; c < 160; c++) begin
      r = $urandom_range(0, NT);
      act = (r == NT) ? '0 : (NT'(1) << r);
      if ($urandom_range(0, 4) == 0)
        bus_cycle(c, 1'b1, $urandom_range(0, NT - 1), 5, 32'($urandom_range(0, 15)), act);
      else
        bus_cycle(c, 1'b0, 0, 0, 32'h0, act);
    end
    for (int t = 0; t < NT; t++) bus_cycle(t, 1'b1, t, 4, 32'h0, 4'b0011);
    for (int c = 0; c < 6; c++) bus_cycle(c, 1'b0, 0, 0, 32'h0, 4'b0101);

    task_active = '0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
